// File: rtl/vapb_arb_pkg.sv
// Shared definitions for the VAPB request arbiter: FSM encodings, slave index width, default sizes.
package vapb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  localparam int SLV_IDX_W       = 3;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NUM_SLV     = 8;
  localparam int DEF_TIMEOUT_CYC = 256;

endpackage

// File: rtl/vapb_rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer (wrapping) wins; one-hot and index outputs.
module vapb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               gnt_any_o,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[IDX_W'(idx)]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = IDX_W'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_oh
    assign gnt_oh_o[gi] = gnt_any_o && (gnt_idx_o == IDX_W'(gi));
  end

endmodule

// File: rtl/vapb_req_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin arbitration.
// Optional ACCESS-phase timeout is enabled by defining VAPB_ARB_TIMEOUT_EN.
module vapb_req_arbiter
  import vapb_arb_pkg::*;
#(
  parameter int NUM_REQ           = DEF_NUM_REQ,
  parameter int APB_ADDRESS_WIDTH = DEF_ADDR_W,
  parameter int APB_DATA_WIDTH    = DEF_DATA_W,
  parameter int NUM_SLV           = DEF_NUM_SLV,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYC
) (
  input  logic                                  apb_pclk,
  input  logic                                  apb_preset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ*SLV_IDX_W-1:0]          req_slv,
  input  logic [NUM_REQ*APB_ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [APB_DATA_WIDTH-1:0]             rsp_rdata,
  output logic                                  rsp_err,
  output logic [NUM_SLV-1:0]                    apb_psel,
  output logic                                  apb_penable,
  output logic                                  apb_pwrite,
  output logic [APB_ADDRESS_WIDTH-1:0]          apb_paddr,
  output logic [APB_DATA_WIDTH-1:0]             apb_pwdata,
  input  logic [APB_DATA_WIDTH-1:0]             apb_prdata,
  input  logic                                  apb_pready,
  input  logic                                  apb_pslverr
);

  localparam int AW    = APB_ADDRESS_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [SLV_IDX_W:0] NUM_SLV_L = (SLV_IDX_W + 1)'(NUM_SLV);

  arb_state_e           state_q;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, owner_q;
  logic [NUM_SLV-1:0]   psel_q;
  logic                 penable_q, pwrite_q;
  logic [AW-1:0]        paddr_q;
  logic [DW-1:0]        pwdata_q, rsp_rdata_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 rsp_err_q;

  logic [SLV_IDX_W-1:0] slv_arr   [NUM_REQ];
  logic [AW-1:0]        addr_arr  [NUM_REQ];
  logic [DW-1:0]        wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign slv_arr[gi]   = req_slv[gi*SLV_IDX_W +: SLV_IDX_W];
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

  logic                 gnt_any;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   arb_req;

  // Requests are only visible to the arbiter while idle, so grants cannot fire mid-transfer.
  assign arb_req = (state_q == ST_IDLE && !apb_preset) ? req_valid : '0;

  vapb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (arb_req),
    .ptr_i     (rr_ptr_q),
    .gnt_any_o (gnt_any),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = gnt_oh;
  assign rr_ptr_d  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  logic [SLV_IDX_W-1:0] slv_sel;
  logic                 slv_bad;
  logic [NUM_SLV-1:0]   psel_dec;
  logic [NUM_REQ-1:0]   owner_oh;

  assign slv_sel = slv_arr[gnt_idx];
  assign slv_bad = {1'b0, slv_sel} >= NUM_SLV_L;

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_psel
    assign psel_dec[gi] = !slv_bad && (slv_sel == SLV_IDX_W'(gi));
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
    assign owner_oh[gi] = (owner_q == IDX_W'(gi));
  end

`ifdef VAPB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge apb_pclk) begin
    if (apb_preset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef VAPB_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            rr_ptr_q <= rr_ptr_d;
            // Out-of-range slave: answer with an error without touching the APB bus.
            if (slv_bad) begin
              rsp_valid_q <= gnt_oh;
              rsp_err_q   <= 1'b1;
            end else begin
              owner_q  <= gnt_idx;
              pwrite_q <= req_write[gnt_idx];
              paddr_q  <= addr_arr[gnt_idx];
              pwdata_q <= wdata_arr[gnt_idx];
              psel_q   <= psel_dec;
              state_q  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
`ifdef VAPB_ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          if (apb_pready) begin
            rsp_valid_q <= owner_oh;
            rsp_rdata_q <= pwrite_q ? '0 : apb_prdata;
            rsp_err_q   <= apb_pslverr;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
`ifdef VAPB_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_q <= owner_oh;
            rsp_err_q   <= 1'b1;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule
